// File: rtl/pong_render_pipe.sv
// Pong pixel generator: per-frame shadow latch of object positions, two-stage
// render pipeline (hit test, then priority colour mux), goal wall-flash and
// ball hiding while paused.
module pong_render_pipe #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned WALL_W       = 32,
    parameter int unsigned PADDLE_W     = 8,
    parameter int unsigned PADDLE_H     = 72,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned FLASH_FRAMES = 16,
    parameter logic [11:0] WALL_COLOR   = 12'hAAA,
    parameter logic [11:0] PADDLE_COLOR = 12'hF00,
    parameter logic [11:0] BALL_COLOR   = 12'hFFF,
    parameter logic [11:0] BG_COLOR     = 12'h000,
    parameter logic [11:0] FLASH_COLOR  = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [9:0]  paddle1_y,
    input  logic [9:0]  paddle2_y,
    input  logic        goal_pulse,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        de_out
);

    // Region bounds, widened to 11 bits so position + size never wraps.
    localparam logic [10:0] L_WALL_L   = 11'(WALL_W);
    localparam logic [10:0] L_WALL_R   = 11'(H_ACTIVE - WALL_W);
    localparam logic [10:0] L_PL_X0    = 11'(WALL_W);
    localparam logic [10:0] L_PL_X1    = 11'(WALL_W + PADDLE_W);
    localparam logic [10:0] L_PR_X0    = 11'(H_ACTIVE - WALL_W - PADDLE_W);
    localparam logic [10:0] L_PR_X1    = 11'(H_ACTIVE - WALL_W);
    localparam logic [10:0] L_PADDLE_H = 11'(PADDLE_H);
    localparam logic [10:0] L_BALL     = 11'(BALL_SIZE);

    // Centred start-up positions.
    localparam logic [9:0] L_BALL_X0   = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0] L_BALL_Y0   = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [9:0] L_PADDLE_Y0 = 10'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [4:0] L_FLASH     = 5'(FLASH_FRAMES);

    logic [9:0]  r_ball_x, r_ball_y, r_paddle1_y, r_paddle2_y;
    logic        r_pause;
    logic [4:0]  r_flash_cnt;
    logic        r_vo_d, r_hit_wall, r_hit_paddle, r_hit_ball;
    logic [11:0] r_rgb;
    logic        r_de;

    logic [10:0] w_x, w_y, w_bx, w_by, w_p1, w_p2;
    logic        w_hit_wall, w_hit_paddle, w_hit_ball, w_flash_on;
    logic [11:0] w_pix;

    // Shadow copies of object state, refreshed only at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ball_x    <= L_BALL_X0;
            r_ball_y    <= L_BALL_Y0;
            r_paddle1_y <= L_PADDLE_Y0;
            r_paddle2_y <= L_PADDLE_Y0;
            r_pause     <= 1'b0;
        end else if (frame_start) begin
            r_ball_x    <= ball_x;
            r_ball_y    <= ball_y;
            r_paddle1_y <= paddle1_y;
            r_paddle2_y <= paddle2_y;
            r_pause     <= pause;
        end
    end

    // Flash countdown: a goal (re)loads it, each frame start ticks it down.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flash_cnt <= 5'd0;
        end else if (goal_pulse) begin
            r_flash_cnt <= L_FLASH;
        end else if (frame_start && (r_flash_cnt != 5'd0)) begin
            r_flash_cnt <= r_flash_cnt - 5'd1;
        end
    end

    // Stage 1 hit tests against the shadows, in 11-bit arithmetic.
    always_comb begin
        w_x  = {1'b0, x};
        w_y  = {1'b0, y};
        w_bx = {1'b0, r_ball_x};
        w_by = {1'b0, r_ball_y};
        w_p1 = {1'b0, r_paddle1_y};
        w_p2 = {1'b0, r_paddle2_y};

        w_hit_wall   = (w_x < L_WALL_L) || (w_x >= L_WALL_R);
        w_hit_paddle = ((w_x >= L_PL_X0) && (w_x < L_PL_X1) &&
                        (w_y >= w_p1) && (w_y < w_p1 + L_PADDLE_H)) ||
                       ((w_x >= L_PR_X0) && (w_x < L_PR_X1) &&
                        (w_y >= w_p2) && (w_y < w_p2 + L_PADDLE_H));
        w_hit_ball   = !r_pause &&
                       (w_x >= w_bx) && (w_x < w_bx + L_BALL) &&
                       (w_y >= w_by) && (w_y < w_by + L_BALL);
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vo_d       <= 1'b0;
            r_hit_wall   <= 1'b0;
            r_hit_paddle <= 1'b0;
            r_hit_ball   <= 1'b0;
        end else begin
            r_vo_d       <= video_on;
            r_hit_wall   <= w_hit_wall;
            r_hit_paddle <= w_hit_paddle;
            r_hit_ball   <= w_hit_ball;
        end
    end

    // Stage 2 priority mux: blank, wall, paddle, ball, background.
    always_comb begin
        w_flash_on = (r_flash_cnt != 5'd0) && r_flash_cnt[2];
        w_pix      = BG_COLOR;
        if (!r_vo_d) begin
            w_pix = 12'h000;
        end else if (r_hit_wall) begin
            w_pix = w_flash_on ? FLASH_COLOR : WALL_COLOR;
        end else if (r_hit_paddle) begin
            w_pix = PADDLE_COLOR;
        end else if (r_hit_ball) begin
            w_pix = BALL_COLOR;
        end
    end

    // Stage 2 register drives the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb <= 12'h000;
            r_de  <= 1'b0;
        end else begin
            r_rgb <= w_pix;
            r_de  <= r_vo_d;
        end
    end

    assign rgb    = r_rgb;
    assign de_out = r_de;

endmodule

// File: tb/tb_pong_render_pipe.sv
// Self-checking bench for pong_render_pipe: directed edge cases followed by
// randomized pixel streams, all against a region-arithmetic reference model.
module tb_pong_render_pipe;

    localparam int FLASH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y, ball_x, ball_y, paddle1_y, paddle2_y;
    logic        video_on, frame_start, goal_pulse, pause;
    logic [11:0] rgb;
    logic        de_out;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: what the screen should show this frame.
    int m_bx = 316, m_by = 236, m_p1 = 204, m_p2 = 204, m_cnt = 0;
    bit m_pause = 1'b0;

    logic [12:0] q[$];

    pong_render_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .frame_start (frame_start),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .paddle1_y   (paddle1_y),
        .paddle2_y   (paddle2_y),
        .goal_pulse  (goal_pulse),
        .pause       (pause),
        .rgb         (rgb),
        .de_out      (de_out)
    );

    always #5 clk = ~clk;

    function automatic bit inside_box(int px, int py, int x0, int w, int y0, int h);
        return (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);
    endfunction

    function automatic logic [12:0] ref_out(int px, int py, bit vo);
        logic [11:0] c;
        if (!vo) return 13'h0;
        if (px < 32 || px >= 608)
            c = (m_cnt != 0 && ((m_cnt / 4) % 2 == 1)) ? 12'hFF0 : 12'hAAA;
        else if (inside_box(px, py, 32, 8, m_p1, 72) || inside_box(px, py, 600, 8, m_p2, 72))
            c = 12'hF00;
        else if (!m_pause && inside_box(px, py, m_bx, 8, m_by, 8))
            c = 12'hFFF;
        else
            c = 12'h000;
        return {1'b1, c};
    endfunction

    task automatic check(input logic [12:0] exp, input string tag);
        vectors++;
        assert ({de_out, rgb} === exp) else begin
            miscompares++;
            $error("FAIL %s: de_out/rgb=%0b/%h expected %0b/%h",
                   tag, de_out, rgb, exp[12], exp[11:0]);
        end
    endtask

    task automatic pix(input int px, input int py, input bit vo, input string tag);
        @(negedge clk);
        x = 10'(px); y = 10'(py); video_on = vo;
        @(negedge clk);
        @(negedge clk);
        check(ref_out(px, py, vo), tag);
    endtask

    task automatic set_obj(input int bx, input int by, input int p1, input int p2, input bit ps);
        ball_x = 10'(bx); ball_y = 10'(by);
        paddle1_y = 10'(p1); paddle2_y = 10'(p2); pause = ps;
    endtask

    task automatic pulse(input bit fs, input bit gp);
        @(negedge clk);
        frame_start = fs; goal_pulse = gp;
        if (gp) m_cnt = FLASH;
        else if (fs && m_cnt != 0) m_cnt--;
        if (fs) begin
            m_bx = ball_x; m_by = ball_y; m_p1 = paddle1_y; m_p2 = paddle2_y; m_pause = pause;
        end
        @(negedge clk);
        frame_start = 1'b0; goal_pulse = 1'b0;
    endtask

    task automatic model_reset();
        m_bx = 316; m_by = 236; m_p1 = 204; m_p2 = 204; m_pause = 1'b0; m_cnt = 0;
    endtask

    // Random pixel stream, checked in flight to pin the latency at two clocks.
    task automatic stream(input int n);
        int px, py;
        bit vo;
        q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() >= 2) check(q.pop_front(), "stream");
            case ($urandom_range(0, 3))
                0: begin px = $urandom_range(0, 1023); py = $urandom_range(0, 1023); end
                1: begin px = m_bx + $urandom_range(0, 15) - 4; py = m_by + $urandom_range(0, 15) - 4; end
                2: begin px = $urandom_range(28, 44); py = m_p1 + $urandom_range(0, 79) - 4; end
                default: begin px = $urandom_range(596, 612); py = m_p2 + $urandom_range(0, 79) - 4; end
            endcase
            px = px & 1023; py = py & 1023;
            vo = ($urandom_range(0, 7) != 0);
            x = 10'(px); y = 10'(py); video_on = vo;
            q.push_back(ref_out(px, py, vo));
        end
    endtask

    initial begin
        rst = 1'b1; x = '0; y = '0; video_on = 1'b0; frame_start = 1'b0; goal_pulse = 1'b0;
        set_obj(0, 0, 0, 0, 1'b0);

        // Reset state.
        video_on = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check(13'h0, "reset_out");
        rst = 1'b0;

        // Latency and reset shadows.
        pix(0, 0, 1'b1, "lat_wall");
        pix(0, 0, 1'b0, "lat_blank");
        pix(316, 236, 1'b1, "rst_ball");
        pix(32, 204, 1'b1, "rst_paddle1");
        pix(600, 275, 1'b1, "rst_paddle2");

        // Paddle and wall edges.
        set_obj(300, 200, 100, 100, 1'b0);
        pulse(1'b1, 1'b0);
        pix(31, 100, 1'b1, "edge_wall31");
        pix(32, 100, 1'b1, "edge_p1_left");
        pix(39, 171, 1'b1, "edge_p1_bot");
        pix(39, 172, 1'b1, "edge_p1_below");
        pix(40, 100, 1'b1, "edge_p1_right");
        pix(600, 100, 1'b1, "edge_p2_left");
        pix(608, 100, 1'b1, "edge_wall608");

        // Tear-free latch.
        set_obj(400, 400, 100, 100, 1'b0);
        pix(300, 200, 1'b1, "tear_old_ball");
        pix(400, 400, 1'b1, "tear_new_hidden");
        pulse(1'b1, 1'b0);
        pix(400, 400, 1'b1, "tear_new_ball");
        pix(300, 200, 1'b1, "tear_old_gone");

        // No wrap.
        set_obj(636, 476, 1020, 100, 1'b0);
        pulse(1'b1, 1'b0);
        for (int i = 0; i <= 10; i++) pix(32, i, 1'b1, $sformatf("nowrap_p1_y%0d", i));
        pix(1023, 100, 1'b1, "nowrap_p1_far");
        pix(639, 479, 1'b1, "nowrap_ball_wall");

        // Flash sequence.
        set_obj(300, 200, 100, 100, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pix(0, 100, 1'b1, "flash_goal_frame");
        for (int f = 1; f <= 17; f++) begin
            pulse(1'b1, 1'b0);
            pix(0, 100, 1'b1, $sformatf("flash_after_%0d", f));
        end
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pix(639, 50, 1'b1, "flash_restart");
        pulse(1'b1, 1'b0);
        pix(639, 50, 1'b1, "flash_restart_15");
        pulse(1'b1, 1'b1);
        pix(0, 0, 1'b1, "flash_coincident");
        pulse(1'b1, 1'b0);
        pix(0, 0, 1'b1, "flash_coincident_next");

        // Pause.
        set_obj(300, 200, 100, 100, 1'b1);
        pulse(1'b1, 1'b0);
        pix(303, 203, 1'b1, "pause_hidden");
        pause = 1'b0;
        pix(303, 203, 1'b1, "pause_still_hidden");
        pulse(1'b1, 1'b0);
        pix(303, 203, 1'b1, "pause_shown");

        // Mid-frame reset.
        set_obj(500, 300, 50, 300, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pix(0, 0, 1'b1, "pre_reset_flash");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check(13'h0, "mid_reset_out");
        rst = 1'b0;
        model_reset();
        pix(0, 0, 1'b1, "post_reset_wall");
        pix(318, 238, 1'b1, "post_reset_ball");
        pix(500, 300, 1'b1, "post_reset_old_ball");

        // Randomized frames.
        for (int r = 0; r < 8; r++) begin
            set_obj($urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                    ($urandom_range(0, 3) == 0));
            pulse(1'b1, ($urandom_range(0, 2) == 0));
            set_obj($urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0);
            stream(150);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pong_render_pipe.md
Name: pong_render_pipe

Overview:
- Registered, parametrised pixel generator for the Pong display path.
- Sits between the VGA sync counter (which supplies x, y, video_on and frame_start) and the RGB output pins.
- Latches object positions once per frame so that objects never tear mid-frame.
- Adds a two-stage render pipeline, a wall-flash effect on a goal, and ball hiding while the game is paused.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- WALL_W, 32, wall width in pixels at each side.
- PADDLE_W, 8, paddle width.
- PADDLE_H, 72, paddle height.
- BALL_SIZE, 8, ball edge length.
- FLASH_FRAMES, 16, frames the wall flash lasts after a goal (max 31).
- WALL_COLOR / PADDLE_COLOR / BALL_COLOR / BG_COLOR / FLASH_COLOR, 12'hAAA / 12'hF00 / 12'hFFF / 12'h000 / 12'hFF0, 4:4:4 colours.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- x  in  10  current pixel column
- y  in  10  current pixel row
- video_on  in  1  active-region flag
- frame_start  in  1  one-cycle pulse, once per frame, during vertical blank
- ball_x, ball_y  in  10 each  ball top-left corner
- paddle1_y, paddle2_y  in  10 each  top edge of the left and right paddles
- goal_pulse  in  1  one-cycle pulse from the game logic when a point is scored
- pause  in  1  level; hides the ball
- rgb  out  12  registered pixel colour
- de_out  out  1  video_on delayed to align with rgb

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - rgb = 0, de_out = 0, flash_cnt = 0.
  - Shadow ball = (H_ACTIVE/2 - BALL_SIZE/2, V_ACTIVE/2 - BALL_SIZE/2) = (316, 236).
  - Shadow paddles = (V_ACTIVE - PADDLE_H)/2 = 204.
  - Shadow pause = 0.
- Shadow registers:
  - On a frame_start cycle, ball_x, ball_y, paddle1_y, paddle2_y and pause are copied into shadows.
  - All hit tests use only the shadows; input changes between frame_start pulses have no visible effect.
- Pipeline, latency exactly 2 clocks from (x, y, video_on) to (rgb, de_out):
  - Stage 1 registers x, y, video_on and hit flags: wall, paddle, ball.
  - Stage 2 applies a priority mux and registers rgb and de_out.
- Hit regions (all half-open; comparisons done in 11 bits, so position+size never wraps):
  - Wall: x < WALL_W, or x >= H_ACTIVE - WALL_W.
  - Left paddle: WALL_W <= x < WALL_W + PADDLE_W, and p1 <= y < p1 + PADDLE_H.
  - Right paddle: H_ACTIVE - WALL_W - PADDLE_W <= x < H_ACTIVE - WALL_W, and p2 <= y < p2 + PADDLE_H.
  - Ball: bx <= x < bx + BALL_SIZE, and by <= y < by + BALL_SIZE, and shadow pause = 0.
  - A paddle or ball partly below V_ACTIVE or past H_ACTIVE is clipped naturally; it never wraps to the top or left.
- Priority (stage 2):
  - video_on_d = 0 → rgb = 0.
  - Otherwise, in order: wall, paddle, ball, background.
  - Wall colour is FLASH_COLOR when flash_cnt != 0 and flash_cnt[2] = 1; otherwise WALL_COLOR.
- Flash counter (5 bits):
  - goal_pulse loads FLASH_FRAMES.
  - Else, frame_start with flash_cnt != 0 decrements it.
  - goal_pulse and frame_start in the same cycle: load wins, with no decrement that cycle.
  - goal_pulse during an active flash restarts the count at FLASH_FRAMES.
- Reset mid-frame: outputs return to reset values on the next edge. Rendering resumes 2 cycles after rst deasserts, using the reset shadows until the first frame_start.

Test Plan:
- Pipeline latency: after reset, drive video_on = 1, x = 0, y = 0 → rgb = AAA and de_out = 1 exactly 2 clocks later. Drive video_on = 0 → rgb = 000 and de_out = 0 2 clocks later.
- Paddle and wall edges, with p1 = 100 latched:
  - (x=31, y=100) → AAA.
  - (x=32, y=100) → F00.
  - (x=39, y=171) → F00.
  - (x=39, y=172) → 000.
  - (x=40, y=100) → 000.
  - With p2 = 100, (x=600, y=100) → F00 and (x=608, y=100) → AAA.
- Tear-free latch:
  - Ball inputs (300, 200), frame_start pulse, then change inputs to (400, 400) mid-frame → pixel (300, 200) = FFF and pixel (400, 400) = 000 until the next frame_start.
  - After the next frame_start → pixel (400, 400) = FFF and pixel (300, 200) = 000.
- No wrap: p1 = 1020 latched → (x=32, y=0..10) = 000, not F00. Ball (636, 476) → pixel (639, 479) = AAA, because the wall has priority over the ball.
- Flash sequence: goal_pulse → wall = AAA during the current frame.
  - Frames after 1, 2, 3, 4 frame_starts (cnt 15..12) → FF0.
  - Frames at cnt 11..8 → AAA.
  - After 16 frame_starts → AAA permanently.
  - goal_pulse coincident with frame_start → cnt = 16, not 15.
- Pause: pause = 1 latched at frame_start → ball pixels show 000. Pause deasserted but no frame_start yet → ball still hidden.
